// File: rtl/i2c_txn_arbiter_pkg.sv
// Shared types and constants for the I2C transaction arbiter and the sensor-side
// controllers that request register accesses through it.
package i2c_pkg;

  typedef enum logic [2:0] {IDLE, CMD0, CMD1, LAST, RECOVER, DONE} txn_state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  // LSM303 accelerometer
  localparam logic [6:0] ACC_DEV      = 7'h18;
  localparam logic [7:0] CTRL_REG1_A  = 8'h20;
  localparam logic [7:0] STATUS_REG_A = 8'h27;
  localparam logic [7:0] OUT_Z_L_A    = 8'h2C;
  localparam logic [7:0] OUT_Z_H_A    = 8'h2D;

  typedef struct packed {
    logic       we;
    logic [6:0] dev;
    logic [7:0] sub;
    logic [7:0] wdata;
  } txn_t;

  // Watchdog is never narrower than 13 bits so the default 4096 limit always fits.
  function automatic int wd_width(input int t);
    int w;
    w = $clog2(t) + 1;
    return (w > 13) ? w : 13;
  endfunction

endpackage

// File: rtl/i2c_txn_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// The pointer register itself lives in the parent.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] winner,
  output logic [N-1:0]  onehot
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest set request is written last.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    onehot = '0;
    idx    = 0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % N;
      if (req[idx]) begin
        any         = 1'b1;
        winner      = PW'(idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one i2c_master between N_REQ single-register requesters: round-robin
// grant, ena/busy handshake sequencing, and a per-phase watchdog.
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_we,
  input  logic [7*N_REQ-1:0] req_dev,
  input  logic [8*N_REQ-1:0] req_reg,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [7:0]         rdata,
  output logic               err,
  output logic               i2c_ena,
  output logic [6:0]         i2c_addr,
  output logic               i2c_rw,
  output logic [7:0]         i2c_data_wr,
  input  logic               i2c_busy,
  input  logic [7:0]         i2c_data_rd,
  input  logic               i2c_ack_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = wd_width(TIMEOUT_CYC);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);

  txn_state_t        state;
  txn_t              sel, txn;
  logic              busy_q, rise, fall, wd_hit, any;
  logic [PW-1:0]     rr_ptr, winner, next_ptr;
  logic [N_REQ-1:0]  onehot;
  logic [WW-1:0]     wd;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req    (req),
    .ptr    (rr_ptr),
    .any    (any),
    .winner (winner),
    .onehot (onehot)
  );

  always_comb begin
    sel.we    = req_we[winner];
    sel.dev   = req_dev[7*winner +: 7];
    sel.sub   = req_reg[8*winner +: 8];
    sel.wdata = req_wdata[8*winner +: 8];
  end

  assign next_ptr = (winner == PW'(N_REQ - 1)) ? '0 : winner + 1'b1;
  assign rise     = i2c_busy & ~busy_q;
  assign fall     = ~i2c_busy & busy_q;
  // wd counts cycles already spent in the phase; hitting WD_LAST means the limit is used up.
  assign wd_hit   = (wd == WD_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      txn         <= '0;
      busy_q      <= 1'b0;
      rr_ptr      <= '0;
      wd          <= '0;
      gnt         <= '0;
      done        <= '0;
      rdata       <= '0;
      err         <= 1'b0;
      i2c_ena     <= 1'b0;
      i2c_addr    <= '0;
      i2c_rw      <= 1'b0;
      i2c_data_wr <= '0;
    end else begin
      busy_q <= i2c_busy;
      done   <= '0;
      wd     <= wd + 1'b1;
      case (state)
        IDLE: begin
          wd <= '0;
          if (any) begin
            txn         <= sel;
            gnt         <= onehot;
            rr_ptr      <= next_ptr;
            err         <= 1'b0;
            i2c_ena     <= 1'b1;
            i2c_addr    <= sel.dev;
            i2c_rw      <= I2C_RW_WRITE;
            i2c_data_wr <= sel.sub;
            state       <= CMD0;
          end
        end
        CMD0: begin
          if (rise) begin
            // A read flips rw here, which the master turns into a repeated start.
            i2c_rw      <= txn.we ? I2C_RW_WRITE : I2C_RW_READ;
            i2c_data_wr <= txn.we ? txn.wdata : i2c_data_wr;
            wd          <= '0;
            state       <= CMD1;
          end else if (wd_hit) begin
            i2c_ena <= 1'b0;
            err     <= 1'b1;
            wd      <= '0;
            state   <= RECOVER;
          end
        end
        CMD1: begin
          if (rise) begin
            i2c_ena <= 1'b0;
            wd      <= '0;
            state   <= LAST;
          end else if (wd_hit) begin
            i2c_ena <= 1'b0;
            err     <= 1'b1;
            wd      <= '0;
            state   <= RECOVER;
          end
        end
        LAST: begin
          if (fall) begin
            if (!txn.we) rdata <= i2c_data_rd;
            err   <= i2c_ack_err;
            done  <= gnt;
            wd    <= '0;
            state <= DONE;
          end else if (wd_hit) begin
            i2c_ena <= 1'b0;
            err     <= 1'b1;
            wd      <= '0;
            state   <= RECOVER;
          end
        end
        RECOVER: begin
          if (!i2c_busy || wd_hit) begin
            err   <= 1'b1;
            done  <= gnt;
            wd    <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          gnt   <= '0;
          wd    <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Randomised bench for i2c_txn_arbiter with a byte-level i2c_master model and a
// round-robin/transaction reference model.
module tb_i2c_txn_arbiter;
  import i2c_pkg::*;

  localparam int N    = 2;
  localparam int TO   = 64;
  localparam int RS   = 256;
  localparam int STOP = 512;

  logic           sys_clk = 1'b0;
  logic           sys_rst = 1'b1;
  logic [N-1:0]   req = '0, req_we = '0;
  logic [7*N-1:0] req_dev = '0;
  logic [8*N-1:0] req_reg = '0, req_wdata = '0;
  logic [N-1:0]   gnt, done;
  logic [7:0]     rdata, i2c_data_wr;
  logic           err, i2c_ena, i2c_rw;
  logic [6:0]     i2c_addr;
  logic           i2c_busy = 1'b0;
  logic [7:0]     i2c_data_rd = '0;
  logic           i2c_ack_err = 1'b0;

  int checks = 0, errors = 0;

  // master model state: bmode 0 normal, 1 never goes busy, 2 busy stuck high
  int         bmode = 0, bst = 0, bcnt = 0;
  logic       nack_en = 1'b0, cur_rw = 1'b0;
  logic [7:0] rd_byte = '0;
  logic [6:0] cur_addr = '0;
  int         buslog[$];

  int         mptr = 0;
  logic [7:0] mrdata = '0;

  i2c_txn_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req), .req_we(req_we),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .err(err),
    .i2c_ena(i2c_ena), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw),
    .i2c_data_wr(i2c_data_wr), .i2c_busy(i2c_busy),
    .i2c_data_rd(i2c_data_rd), .i2c_ack_err(i2c_ack_err)
  );

  always #5 sys_clk = ~sys_clk;

  // Byte-level master: busy high per byte, one low cycle between bytes where it
  // looks at ena to decide between continuing and STOP.
  always @(negedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      i2c_busy = 1'b0; i2c_ack_err = 1'b0; bst = 0;
    end else begin
      case (bst)
        0: if (i2c_ena && bmode != 1) begin
          buslog.push_back(int'({i2c_addr, i2c_rw}));
          if (!i2c_rw) buslog.push_back(int'(i2c_data_wr));
          cur_rw = i2c_rw; cur_addr = i2c_addr;
          i2c_ack_err = nack_en; i2c_busy = 1'b1;
          bcnt = $urandom_range(12, 3); bst = 1;
        end
        1: if (bmode != 2) begin
          bcnt--;
          if (bcnt == 0) begin
            if (cur_rw) i2c_data_rd = rd_byte;
            i2c_busy = 1'b0; bst = 2;
          end
        end
        default: if (i2c_ena) begin
          if (i2c_rw != cur_rw || i2c_addr != cur_addr) begin
            buslog.push_back(RS);
            buslog.push_back(int'({i2c_addr, i2c_rw}));
            cur_rw = i2c_rw; cur_addr = i2c_addr;
          end
          if (!i2c_rw) buslog.push_back(int'(i2c_data_wr));
          i2c_busy = 1'b1; bcnt = $urandom_range(12, 3); bst = 1;
        end else begin
          buslog.push_back(STOP); bst = 0;
        end
      endcase
    end
  end

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic bit bus_matches(input logic we, input logic [6:0] dev,
                                     input logic [7:0] sub, input logic [7:0] wd);
    int e[$];
    e.push_back(int'({dev, 1'b0}));
    e.push_back(int'(sub));
    if (we) e.push_back(int'(wd));
    else begin e.push_back(RS); e.push_back(int'({dev, 1'b1})); end
    e.push_back(STOP);
    if (e.size() != buslog.size()) return 1'b0;
    foreach (e[k]) if (e[k] != buslog[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_fields(input int i, input logic we, input logic [6:0] dev,
                            input logic [7:0] sub, input logic [7:0] wd);
    req_we[i] = we;
    req_dev[7*i +: 7] = dev;
    req_reg[8*i +: 8] = sub;
    req_wdata[8*i +: 8] = wd;
  endtask

  task automatic wait_done(input int limit, output logic [N-1:0] dv, output logic to,
                           output logic multi, output int cyc);
    dv = '0; to = 1'b0; multi = 1'b0; cyc = 0;
    while (1) begin
      @(negedge sys_clk); cyc++;
      if ($countones(gnt) > 1) multi = 1'b1;
      if (|done) begin dv = done; break; end
      if (cyc >= limit) begin to = 1'b1; break; end
    end
  endtask

  // One requester runs one transaction; it drops req when it sees done.
  task automatic txn(input int idx, input logic we, input logic [6:0] dev, input logic [7:0] sub,
                     input logic [7:0] wd, input logic [7:0] rdb, input logic nk,
                     output logic [N-1:0] dv, output logic [7:0] rd, output logic er,
                     output logic to, output logic multi, output logic pulse_ok);
    int cyc;
    rd_byte = rdb; nack_en = nk; buslog.delete();
    set_fields(idx, we, dev, sub, wd);
    req[idx] = 1'b1;
    wait_done(400, dv, to, multi, cyc);
    rd = rdata; er = err;
    req[idx] = 1'b0;
    @(negedge sys_clk);
    pulse_ok = (done == '0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge sys_clk);
    checks++; if ({gnt, done, err, i2c_ena, i2c_rw} !== '0) begin errors++;
      $display("FAIL reset_ctrl: got gnt=%b done=%b err=%b ena=%b rw=%b want 0", gnt, done, err, i2c_ena, i2c_rw); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    checks++; if (i2c_addr !== 7'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", i2c_addr); end
    checks++; if (i2c_data_wr !== 8'h00) begin errors++; $display("FAIL reset_data_wr: got %h want 00", i2c_data_wr); end
    sys_rst = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic test_write;
    logic [N-1:0] dv; logic [7:0] rd; logic er, to, mu, pk;
    txn(0, 1'b1, ACC_DEV, CTRL_REG1_A, 8'h74, 8'h00, 1'b0, dv, rd, er, to, mu, pk);
    checks++; if (dv !== 2'b01 || to) begin errors++; $display("FAIL write_done: got %b timeout=%0d want 01", dv, to); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL write_err: got %b want 0", er); end
    checks++; if (!pk) begin errors++; $display("FAIL write_pulse: done=%b want 00 one cycle later", done); end
    checks++; if (!bus_matches(1'b1, ACC_DEV, CTRL_REG1_A, 8'h74)) begin errors++;
      $display("FAIL write_bus: got %0d events first %h want 30 20 74 stop", buslog.size(), buslog[0]); end
    checks++; if (rd !== mrdata) begin errors++; $display("FAIL write_rdata: got %h want %h", rd, mrdata); end
  endtask

  task automatic test_read;
    logic [N-1:0] dv; logic [7:0] rd; logic er, to, mu, pk;
    txn(1, 1'b0, ACC_DEV, STATUS_REG_A, 8'h00, 8'h08, 1'b0, dv, rd, er, to, mu, pk);
    mrdata = 8'h08;
    checks++; if (dv !== 2'b10 || to) begin errors++; $display("FAIL read_done: got %b timeout=%0d want 10", dv, to); end
    checks++; if (rd !== 8'h08 || er !== 1'b0) begin errors++; $display("FAIL read_data: got %h err=%b want 08 err=0", rd, er); end
    checks++; if (!bus_matches(1'b0, ACC_DEV, STATUS_REG_A, 8'h00)) begin errors++;
      $display("FAIL read_bus: got %0d events want 30 27 rs 31 stop", buslog.size()); end
  endtask

  task automatic test_nack;
    logic [N-1:0] dv; logic [7:0] rd; logic er, to, mu, pk;
    txn(0, 1'b1, ACC_DEV, CTRL_REG1_A, 8'h57, 8'hEE, 1'b1, dv, rd, er, to, mu, pk);
    nack_en = 1'b0;
    checks++; if (dv !== 2'b01 || er !== 1'b1) begin errors++; $display("FAIL nack_err: got done=%b err=%b want 01 1", dv, er); end
    checks++; if (rd !== mrdata) begin errors++; $display("FAIL nack_rdata: got %h want %h", rd, mrdata); end
  endtask

  task automatic test_timeout;
    int n;
    bmode = 1;
    set_fields(0, 1'b1, ACC_DEV, CTRL_REG1_A, 8'h11);
    req[0] = 1'b1;
    n = 0;
    while (!i2c_ena && n < 20) begin @(negedge sys_clk); n++; end
    n = 0;
    while (i2c_ena && n < 200) begin @(negedge sys_clk); n++; end
    checks++; if (n !== TO) begin errors++; $display("FAIL timeout_ena: ena high %0d cycles want %0d", n, TO); end
    while (!done[0] && n < 200) begin @(negedge sys_clk); n++; end
    req[0] = 1'b0;
    checks++; if (!done[0] || n > 67 || err !== 1'b1) begin errors++;
      $display("FAIL timeout_done: done at %0d err=%b want <=67 err=1", n, err); end
    checks++; if (rdata !== mrdata) begin errors++; $display("FAIL timeout_rdata: got %h want %h", rdata, mrdata); end
    bmode = 0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_stuck;
    int n;
    bmode = 2;
    set_fields(1, 1'b0, ACC_DEV, OUT_Z_L_A, 8'h00);
    req[1] = 1'b1;
    n = 0;
    while (!i2c_ena && n < 20) begin @(negedge sys_clk); n++; end
    n = 0;
    while (!done[1] && n < 400) begin @(negedge sys_clk); n++; end
    req[1] = 1'b0;
    checks++; if (!done[1] || n < 2*TO || n > 2*TO + 8 || err !== 1'b1) begin errors++;
      $display("FAIL stuck_done: done at %0d err=%b want %0d..%0d err=1", n, err, 2*TO, 2*TO + 8); end
    checks++; if (rdata !== mrdata) begin errors++; $display("FAIL stuck_rdata: got %h want %h", rdata, mrdata); end
    bmode = 0;
    repeat (30) @(negedge sys_clk);
    buslog.delete();
  endtask

  task automatic test_contention;
    logic [N-1:0] dv, ev; logic to, mu; int cyc;
    int exp_order[4] = '{0, 1, 0, 1};
    sys_rst = 1'b1;
    set_fields(0, 1'b1, ACC_DEV, CTRL_REG1_A, 8'h3C);
    set_fields(1, 1'b1, ACC_DEV, OUT_Z_H_A, 8'hA5);
    req = 2'b11;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    mrdata = '0;
    for (int k = 0; k < 4; k++) begin
      wait_done(400, dv, to, mu, cyc);
      if (k == 3) req = '0;
      ev = '0; ev[exp_order[k]] = 1'b1;
      checks++; if (dv !== ev || to) begin errors++; $display("FAIL contention_order%0d: got %b want %b", k, dv, ev); end
      checks++; if (mu) begin errors++; $display("FAIL contention_onehot%0d: more than one gnt bit seen", k); end
    end
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_reset_mid;
    logic [N-1:0] dv; logic to, mu; int cyc;
    logic [7:0] wv, sv;
    nack_en = 1'b0; buslog.delete();
    set_fields(0, 1'b1, ACC_DEV, CTRL_REG1_A, 8'h99);
    req = 2'b01;
    cyc = 0;
    while (!i2c_busy && cyc < 100) begin @(negedge sys_clk); cyc++; end
    @(posedge sys_clk); @(negedge sys_clk);
    checks++; if (i2c_ena !== 1'b1 || gnt !== 2'b01 || cyc >= 100) begin errors++;
      $display("FAIL mid_pre: got ena=%b gnt=%b want 1 01", i2c_ena, gnt); end
    sys_rst = 1'b1; req = '0;
    @(negedge sys_clk);
    checks++; if (i2c_ena !== 1'b0 || gnt !== '0 || done !== '0) begin errors++;
      $display("FAIL mid_reset: got ena=%b gnt=%b done=%b want 0 00 00", i2c_ena, gnt, done); end
    sys_rst = 1'b0; mrdata = '0;
    @(negedge sys_clk);
    buslog.delete();
    wv = 8'($urandom); sv = 8'($urandom); rd_byte = 8'($urandom);
    set_fields(0, 1'b1, ACC_DEV, sv, wv);
    set_fields(1, 1'b0, ACC_DEV, STATUS_REG_A, 8'h00);
    req = 2'b11;
    wait_done(400, dv, to, mu, cyc);
    req[0] = 1'b0;
    checks++; if (dv !== 2'b01 || err !== 1'b0) begin errors++; $display("FAIL mid_first: got %b err=%b want 01 0 (rr_ptr reset)", dv, err); end
    @(negedge sys_clk);
    checks++; if (!bus_matches(1'b1, ACC_DEV, sv, wv)) begin errors++; $display("FAIL mid_bus: got %0d events", buslog.size()); end
    buslog.delete();
    wait_done(400, dv, to, mu, cyc);
    req[1] = 1'b0;
    checks++; if (dv !== 2'b10 || rdata !== rd_byte || err !== 1'b0) begin errors++;
      $display("FAIL mid_second: got %b rdata=%h err=%b want 10 %h 0", dv, rdata, err, rd_byte); end
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_random;
    logic         mwe[N];
    logic [6:0]   mdev[N];
    logic [7:0]   msub[N], mwd[N], exp_rd;
    logic [N-1:0] pend, dv, ev;
    logic         to, mu, nk, er;
    logic [7:0]   rd;
    int           w, cyc;
    sys_rst = 1'b1; req = '0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0; mptr = 0; mrdata = '0; pend = '0;
    @(negedge sys_clk);
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(1, 0) == 1) begin
          mwe[i] = 1'($urandom); mdev[i] = 7'($urandom); msub[i] = 8'($urandom); mwd[i] = 8'($urandom);
          set_fields(i, mwe[i], mdev[i], msub[i], mwd[i]); pend[i] = 1'b1;
        end
      if (pend == '0) begin
        w = $urandom_range(N - 1, 0);
        mwe[w] = 1'($urandom); mdev[w] = 7'($urandom); msub[w] = 8'($urandom); mwd[w] = 8'($urandom);
        set_fields(w, mwe[w], mdev[w], msub[w], mwd[w]); pend[w] = 1'b1;
      end
      rd_byte = 8'($urandom); nk = ($urandom_range(3, 0) == 0); nack_en = nk;
      buslog.delete();
      req = pend;
      w = pick(pend, mptr);
      wait_done(400, dv, to, mu, cyc);
      rd = rdata; er = err;
      pend = pend & ~dv; req = pend;
      @(negedge sys_clk);
      ev = '0; ev[w] = 1'b1;
      exp_rd = mwe[w] ? mrdata : rd_byte;
      mrdata = exp_rd;
      mptr = (w + 1) % N;
      checks++; if (dv !== ev || to) begin errors++; $display("FAIL rand%0d_winner: got %b want %b", it, dv, ev); end
      checks++; if (er !== nk || rd !== exp_rd) begin errors++;
        $display("FAIL rand%0d_result: got rdata=%h err=%b want %h %b", it, rd, er, exp_rd, nk); end
      checks++; if (!bus_matches(mwe[w], mdev[w], msub[w], mwd[w])) begin errors++;
        $display("FAIL rand%0d_bus: got %0d events for we=%b", it, buslog.size(), mwe[w]); end
      checks++; if (done !== '0 || mu) begin errors++; $display("FAIL rand%0d_pulse: done=%b multi_gnt=%b", it, done, mu); end
    end
    req = '0; nack_en = 1'b0;
    repeat (3) @(negedge sys_clk);
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_nack;
    test_timeout;
    test_stuck;
    test_contention;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: bench did not complete within its time bound");
    $fatal(1, "bench time bound expired");
  end

endmodule
